cpu_mem_responder: RTL and testbench



---
 rtl/cpu_mem_responder.sv | 108 ++++++++++
 tb/tb_cpu_mem_responder.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the pipelined CPU: instruction/data memories,
// CPU fetch and data ports, host load port and run/stop control.
module cpu_mem_responder #(
  parameter int unsigned AW    = 8,
  parameter int unsigned DW    = 16,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [AW-1:0]    pc,
  output logic [DW-1:0]    id_ir,
  input  logic [AW-1:0]    data_address,
  input  logic             dw,
  input  logic [DW-1:0]    smdr1,
  output logic [DW-1:0]    read_data,
  output logic             cpu_enable,
  output logic             cpu_start,
  input  logic             host_valid,
  output logic             host_ready,
  input  logic [1:0]       host_cmd,
  input  logic [AW-1:0]    host_addr,
  input  logic [DW-1:0]    host_wdata,
  output logic             host_rvalid,
  output logic [DW-1:0]    host_rdata,
  output logic [CNT_W-1:0] run_cycles
);

  localparam int unsigned DEPTH = 1 << AW;
  localparam logic [1:0] CMD_WR_IMEM = 2'b00;
  localparam logic [1:0] CMD_WR_DMEM = 2'b01;
  localparam logic [1:0] CMD_RD_DMEM = 2'b10;
  localparam logic [1:0] CMD_RUN_CTL = 2'b11;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {
    LOCK = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state;
  state_t next_state;

  logic [DW-1:0] imem [DEPTH];
  logic [DW-1:0] dmem [DEPTH];

  logic xfer;
  logic start_req;
  logic stop_req;
  logic host_read;
  logic cpu_write;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= LOCK;
    else       state <= next_state;
  end

  // Next-state logic: run control command toggles LOCK/RUN
  always_comb begin
    next_state = state;
    case (state)
      LOCK: if (start_req) next_state = RUN;
      RUN:  if (stop_req)  next_state = LOCK;
      default: next_state = LOCK;
    endcase
  end

  // Combinational outputs and transfer decode
  always_comb begin
    host_ready = (state == LOCK) || (host_cmd == CMD_RUN_CTL);
    xfer       = host_valid && host_ready;
    start_req  = xfer && (host_cmd == CMD_RUN_CTL) && host_wdata[0] && (state == LOCK);
    stop_req   = xfer && (host_cmd == CMD_RUN_CTL) && !host_wdata[0] && (state == RUN);
    host_read  = xfer && (host_cmd == CMD_RD_DMEM);
    cpu_write  = dw && (state == RUN);
    id_ir      = (state == RUN) ? imem[pc] : '0;
    read_data  = dmem[data_address];
  end

  // Memory writes; host writes only happen in LOCK, CPU writes only in RUN
  always_ff @(posedge clock) begin
    if (xfer && (host_cmd == CMD_WR_IMEM)) imem[host_addr] <= host_wdata;
    if (xfer && (host_cmd == CMD_WR_DMEM)) dmem[host_addr] <= host_wdata;
    else if (cpu_write)                    dmem[data_address] <= smdr1;
  end

  // Registered control outputs, host read return and run-cycle counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cpu_enable  <= 1'b0;
      cpu_start   <= 1'b0;
      host_rvalid <= 1'b0;
      host_rdata  <= '0;
      run_cycles  <= '0;
    end else begin
      cpu_start   <= start_req;
      host_rvalid <= host_read;
      if (host_read) host_rdata <= dmem[host_addr];
      if (start_req)     cpu_enable <= 1'b1;
      else if (stop_req) cpu_enable <= 1'b0;
      if (start_req)
        run_cycles <= '0;
      else if ((state == RUN) && (run_cycles != CNT_MAX))
        run_cycles <= run_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Self-checking bench for cpu_mem_responder: directed scenarios followed by
// random traffic, all compared against a transaction-level reference model.
module tb_cpu_mem_responder;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 16;
  localparam int unsigned CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clock;
  logic          reset;
  logic [AW-1:0] pc;
  logic [DW-1:0] id_ir;
  logic [AW-1:0] data_address;
  logic          dw;
  logic [DW-1:0] smdr1;
  logic [DW-1:0] read_data;
  logic          cpu_enable;
  logic          cpu_start;
  logic          host_valid;
  logic          host_ready;
  logic [1:0]    host_cmd;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_rvalid;
  logic [DW-1:0] host_rdata;
  logic [CW-1:0] run_cycles;

  cpu_mem_responder #(.AW(AW), .DW(DW), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .pc(pc), .id_ir(id_ir),
    .data_address(data_address), .dw(dw), .smdr1(smdr1), .read_data(read_data),
    .cpu_enable(cpu_enable), .cpu_start(cpu_start),
    .host_valid(host_valid), .host_ready(host_ready), .host_cmd(host_cmd),
    .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rvalid(host_rvalid), .host_rdata(host_rdata), .run_cycles(run_cycles)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model state
  logic [DW-1:0] imem_m [256];
  logic [DW-1:0] dmem_m [256];
  bit            run_m;
  bit            start_m;
  bit            rvalid_m;
  logic [DW-1:0] rdata_m;
  int            cnt_m;

  int checks;
  int failures;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit v, input logic [1:0] cmd, input logic [AW-1:0] ha,
                       input logic [DW-1:0] wd, input logic [AW-1:0] p,
                       input logic [AW-1:0] da, input bit w, input logic [DW-1:0] sd);
    host_valid = v; host_cmd = cmd; host_addr = ha; host_wdata = wd;
    pc = p; data_address = da; dw = w; smdr1 = sd;
  endtask

  task automatic chk_regs();
    chk("cpu_enable", DW'(cpu_enable), DW'(run_m));
    chk("cpu_start", DW'(cpu_start), DW'(start_m));
    chk("host_rvalid", DW'(host_rvalid), DW'(rvalid_m));
    chk("host_rdata", host_rdata, rdata_m);
    chk("run_cycles", DW'(run_cycles), DW'(cnt_m));
  endtask

  // One clock cycle: check combinational outputs, advance model at the edge,
  // then check registered outputs just after the edge.
  task automatic step();
    bit ready;
    bit xfer;
    ready = !run_m || (host_cmd == 2'b11);
    xfer  = host_valid && ready;
    #1;
    chk("host_ready", DW'(host_ready), DW'(ready));
    chk("id_ir", id_ir, run_m ? imem_m[pc] : '0);
    chk("read_data", read_data, dmem_m[data_address]);
    @(posedge clock);
    rvalid_m = xfer && (host_cmd == 2'b10);
    if (rvalid_m) rdata_m = dmem_m[host_addr];
    if (run_m && dw) dmem_m[data_address] = smdr1;
    if (xfer && host_cmd == 2'b00) imem_m[host_addr] = host_wdata;
    if (xfer && host_cmd == 2'b01) dmem_m[host_addr] = host_wdata;
    start_m = 1'b0;
    if (run_m && cnt_m < CNT_MAX) cnt_m++;
    if (xfer && host_cmd == 2'b11) begin
      if (host_wdata[0] && !run_m) begin
        run_m = 1'b1; start_m = 1'b1; cnt_m = 0;
      end else if (!host_wdata[0] && run_m) begin
        run_m = 1'b0;
      end
    end
    #1;
    chk_regs();
  endtask

  task automatic model_reset();
    run_m = 0; start_m = 0; rvalid_m = 0; rdata_m = '0; cnt_m = 0;
  endtask

  task automatic idle(input logic [AW-1:0] p, input int n);
    drive(0, 2'b00, '0, '0, p, '0, 0, '0);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    checks = 0; failures = 0;
    model_reset();
    reset = 1'b1;
    drive(0, 2'b00, '0, '0, '0, '0, 0, '0);
    #12;
    chk_regs();
    chk("id_ir_reset", id_ir, '0);
    #1 reset = 1'b0;

    // Fill both memories from the host so the model starts fully known
    for (int i = 0; i < 256; i++) begin
      drive(1, 2'b00, AW'(i), DW'($urandom), '0, '0, 0, '0); step();
      drive(1, 2'b01, AW'(i), DW'($urandom), '0, '0, 0, '0); step();
    end

    // Directed: host writes and back-to-back reads
    drive(1, 2'b00, 8'h05, 16'h4A12, 8'h05, '0, 0, '0); step();
    drive(1, 2'b01, 8'h10, 16'hBEEF, 8'h05, '0, 0, '0); step();
    drive(1, 2'b10, 8'h10, '0, 8'h05, '0, 0, '0); step();
    chk("rd_beef", host_rdata, 16'hBEEF);
    drive(1, 2'b10, 8'h11, '0, 8'h05, '0, 0, '0); step();
    chk("rd_b2b_rvalid", DW'(host_rvalid), 16'd1);
    idle(8'h05, 1);
    chk("rd_done_rvalid", DW'(host_rvalid), 16'd0);
    chk("id_ir_lock", id_ir, 16'h0000);

    // Start the CPU
    drive(1, 2'b11, '0, 16'h0001, 8'h05, '0, 0, '0); step();
    chk("start_pulse", DW'(cpu_start), 16'd1);
    chk("id_ir_run", id_ir, 16'h4A12);
    idle(8'h05, 1);
    chk("start_cleared", DW'(cpu_start), 16'd0);
    // Redundant run command: no second start pulse
    drive(1, 2'b11, '0, 16'h0001, 8'h05, '0, 0, '0); step();
    // Host dmem write is refused in RUN
    drive(1, 2'b01, 8'h10, 16'h0BAD, 8'h05, 8'h10, 0, '0); step();
    chk("dmem_guarded", read_data, 16'hBEEF);

    // CPU store in RUN
    drive(0, 2'b00, '0, '0, 8'h05, 8'h20, 1, 16'h1234); step();
    drive(0, 2'b00, '0, '0, 8'h05, 8'h20, 0, '0); step();
    chk("cpu_store", read_data, 16'h1234);

    // Saturate run counter
    idle(8'h05, 20);
    chk("run_sat", DW'(run_cycles), DW'(CNT_MAX));

    // Stop, then a stuck dw in LOCK must not write
    drive(1, 2'b11, '0, 16'h0000, 8'h05, 8'h20, 0, '0); step();
    drive(0, 2'b00, '0, '0, 8'h05, 8'h20, 1, 16'h5555);
    for (int i = 0; i < 3; i++) step();
    chk("lock_no_store", read_data, 16'h1234);
    chk("run_hold", DW'(run_cycles), DW'(CNT_MAX));
    // Redundant stop in LOCK
    drive(1, 2'b11, '0, 16'h0000, 8'h05, '0, 0, '0); step();

    // Re-run clears the counter
    drive(1, 2'b11, '0, 16'h0001, 8'h05, '0, 0, '0); step();
    chk("rerun_clear", DW'(run_cycles), 16'd0);
    idle(8'h07, 3);

    // Asynchronous reset mid-RUN
    reset = 1'b1;
    #1;
    model_reset();
    chk_regs();
    chk("id_ir_async_rst", id_ir, '0);
    #2 reset = 1'b0;
    drive(1, 2'b10, 8'h20, '0, '0, '0, 0, '0); step();
    chk("rd_after_rst", host_rdata, 16'h1234);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic [1:0] c;
      logic [DW-1:0] wd;
      c  = 2'($urandom);
      wd = DW'($urandom);
      drive(($urandom_range(0, 1) == 1), c, AW'($urandom), wd, AW'($urandom),
            AW'($urandom), ($urandom_range(0, 3) == 0), DW'($urandom));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
